// File: rtl/fixp_normalizer.sv
// Normalizes an unsigned fixed-point magnitude with a precomputed leading-zero count into an IEEE-754 binary64 value.
// Optional macro FIXP_NORM_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fixp_normalizer #(
    parameter int FIXP_WIDTH = 192,
    parameter int LZC_WIDTH  = 8,
    parameter int FRAC_BITS  = 96
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_tvalid,
    output logic                              in_tready,
    input  logic [FIXP_WIDTH+LZC_WIDTH:0]     in_tdata,
    output logic                              out_tvalid,
    input  logic                              out_tready,
    output logic [63:0]                       out_tdata,
    output logic                              lzc_err
);

    if (FIXP_WIDTH < 54 || FRAC_BITS > 1022 || (FIXP_WIDTH - 1 - FRAC_BITS) > 1022) begin : g_bad_format
        $error("fixp_normalizer: fixed-point format cannot be represented in binary64");
    end
    if ((2 ** LZC_WIDTH) < FIXP_WIDTH) begin : g_bad_lzc_width
        $error("fixp_normalizer: LZC_WIDTH too narrow for FIXP_WIDTH");
    end

    localparam logic [11:0] EXP_OFFSET = 12'(1023 + FIXP_WIDTH - 1 - FRAC_BITS);

    logic                  advance;

    logic                  s1_valid;
    logic [FIXP_WIDTH-1:0] s1_fixp;
    logic [LZC_WIDTH-1:0]  s1_lzc;
    logic                  s1_find;

    logic [52:0]           norm_top;
    logic                  lzc_bad;
    logic                  s1_zero;
    logic [11:0]           s1_exp;

    logic                  s2_valid;
    logic [51:0]           s2_mant;
    logic                  s2_zero;
    logic [11:0]           s2_exp;

    logic                  round_up;
    logic [52:0]           mant_sum;
    logic [10:0]           exp_final;
    logic [63:0]           packed_result;

    assign advance   = out_tready | ~out_tvalid;
    assign in_tready = advance;

    // Only the leading one and the 52 mantissa bits survive truncation; rounding also needs guard and sticky.
`ifdef FIXP_NORM_RNE_EN
    logic [FIXP_WIDTH-1:0] norm;
    logic                  norm_guard;
    logic                  norm_sticky;
    logic                  s2_guard;
    logic                  s2_sticky;

    assign norm        = s1_fixp << s1_lzc;
    assign norm_top    = norm[FIXP_WIDTH-1 -: 53];
    assign norm_guard  = norm[FIXP_WIDTH-54];
    assign norm_sticky = |(norm << 54);
`else
    assign norm_top = 53'((s1_fixp << s1_lzc) >> (FIXP_WIDTH - 53));
`endif

    // An out-of-range lzc shifts everything out, so a missing leading one covers both inconsistency cases.
    assign lzc_bad = s1_find & ~norm_top[52];
    assign s1_zero = ~s1_find | ~norm_top[52];
    assign s1_exp  = EXP_OFFSET - 12'(s1_lzc);

    always_comb begin
        round_up = 1'b0;
`ifdef FIXP_NORM_RNE_EN
        round_up = s2_guard & (s2_sticky | s2_mant[0]);
`endif
        mant_sum      = {1'b0, s2_mant} + {52'd0, round_up};
        exp_final     = 11'(s2_exp + {11'd0, mant_sum[52]});
        packed_result = 64'd0;
        if (!s2_zero) begin
            packed_result = {1'b0, exp_final, mant_sum[51:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_tvalid <= 1'b0;
            out_tdata  <= 64'd0;
            lzc_err    <= 1'b0;
        end else if (advance) begin
            s1_valid   <= in_tvalid;
            s2_valid   <= s1_valid;
            out_tvalid <= s2_valid;
            out_tdata  <= packed_result;
            if (s1_valid && lzc_bad) begin
                lzc_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_fixp <= in_tdata[FIXP_WIDTH+LZC_WIDTH:LZC_WIDTH+1];
            s1_lzc  <= in_tdata[LZC_WIDTH:1];
            s1_find <= in_tdata[0];
            s2_mant <= norm_top[51:0];
            s2_zero <= s1_zero;
            s2_exp  <= s1_exp;
`ifdef FIXP_NORM_RNE_EN
            s2_guard  <= norm_guard;
            s2_sticky <= norm_sticky;
`endif
        end
    end

endmodule

// File: tb/tb_fixp_normalizer.sv
// Scoreboard bench for fixp_normalizer: directed vectors push expected binary64 results, a monitor pops and compares.
// Expected values for the rounding vectors follow FIXP_NORM_RNE_EN when it is defined.
module tb_fixp_normalizer;

    localparam int W = 192;
    localparam int L = 8;

    logic          clk;
    logic          rst;
    logic          in_tvalid;
    logic          in_tready;
    logic [W+L:0]  in_tdata;
    logic          out_tvalid;
    logic          out_tready;
    logic [63:0]   out_tdata;
    logic          lzc_err;

    fixp_normalizer #(.FIXP_WIDTH(W), .LZC_WIDTH(L), .FRAC_BITS(96)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .lzc_err    (lzc_err)
    );

    typedef struct {
        logic [W-1:0] fixp;
        logic [L-1:0] lzc;
        logic         find;
        logic [63:0]  expected;
    } vec_t;

`ifdef FIXP_NORM_RNE_EN
    localparam logic [63:0] EXP_ONES54  = 64'h45F0_0000_0000_0000;
    localparam logic [63:0] EXP_STICKY  = 64'h45E0_0000_0000_0001;
    localparam logic [63:0] EXP_TIE_ODD = 64'h45E0_0000_0000_0002;
`else
    localparam logic [63:0] EXP_ONES54  = 64'h45EF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_STICKY  = 64'h45E0_0000_0000_0000;
    localparam logic [63:0] EXP_TIE_ODD = 64'h45E0_0000_0000_0001;
`endif

    vec_t        vecs[12];
    logic [63:0] sb_queue[$];
    int          checks = 0;
    int          passed = 0;
    int          beat_idx = 0;
    logic        toggle_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        int  waited;
        logic ready_seen;
        waited = 0;
        #1;
        in_tvalid = 1'b1;
        in_tdata  = {v.fixp, v.lzc, v.find};
        forever begin
            @(negedge clk);
            ready_seen = in_tready;
            @(posedge clk);
            if (ready_seen) begin
                sb_queue.push_back(v.expected);
                break;
            end
            waited++;
            if (waited > 50) begin
                check_output("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        #1;
        in_tvalid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        #1;
        in_tvalid = 1'b0;
        while (sb_queue.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        check_output("drain_empty", 64'(sb_queue.size()), 64'd0);
    endtask

    // Back-pressure source: when enabled, out_tready follows 1,0,0 repeating.
    initial begin
        int ph;
        ph = 0;
        out_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) begin
                out_tready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                out_tready = 1'b1;
                ph = 0;
            end
        end
    end

    // Monitor: pops on every output transfer, checks held data against the queue head while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (out_tvalid) begin
                if (sb_queue.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_output: out_tvalid=1 data %h, expected no beat", out_tdata);
                end else if (out_tready) begin
                    check_output($sformatf("beat%0d", beat_idx), out_tdata, sb_queue[0]);
                    void'(sb_queue.pop_front());
                    beat_idx++;
                end else begin
                    check_output("stall_hold", out_tdata, sb_queue[0]);
                end
            end
        end
    end

    initial begin
        int n;
        vecs[0]  = '{(192'd1 << 96),                               8'd95,  1'b1, 64'h3FF0_0000_0000_0000};
        vecs[1]  = '{{192{1'b1}},                                  8'd0,   1'b0, 64'h0};
        vecs[2]  = '{(192'd1 << 10),                               8'd100, 1'b1, 64'h0};
        vecs[3]  = '{{{54{1'b1}}, 138'd0},                         8'd0,   1'b1, EXP_ONES54};
        vecs[4]  = '{(192'd3 << 96),                               8'd94,  1'b1, 64'h4008_0000_0000_0000};
        vecs[5]  = '{(192'd1 << 191),                              8'd0,   1'b1, 64'h45E0_0000_0000_0000};
        vecs[6]  = '{192'd1,                                       8'd191, 1'b1, 64'h39F0_0000_0000_0000};
        vecs[7]  = '{(192'd1 << 95),                               8'd96,  1'b1, 64'h3FE0_0000_0000_0000};
        vecs[8]  = '{((192'd1 << 191) | (192'd1 << 138)),          8'd0,   1'b1, 64'h45E0_0000_0000_0000};
        vecs[9]  = '{((192'd1 << 191) | (192'd1 << 138) | 192'd1), 8'd0,   1'b1, EXP_STICKY};
        vecs[10] = '{((192'd1 << 191) | (192'd3 << 138)),          8'd0,   1'b1, EXP_TIE_ODD};
        vecs[11] = '{192'd1,                                       8'd200, 1'b1, 64'h0};

        rst       = 1'b1;
        in_tvalid = 1'b0;
        in_tdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_out_tvalid", 64'(out_tvalid), 64'd0);
        check_output("reset_in_tready",  64'(in_tready),  64'd1);
        check_output("reset_lzc_err",    64'(lzc_err),    64'd0);
        check_output("reset_out_tdata",  out_tdata,       64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);

        // Single 1.0 beat with latency measurement.
        apply_stimulus(vecs[0]);
        #1 in_tvalid = 1'b0;
        n = 1;
        forever begin
            @(negedge clk);
            if (out_tvalid || n >= 10) break;
            @(posedge clk);
            n++;
        end
        check_output("latency", 64'(n), 64'd3);
        drain();

        apply_stimulus(vecs[1]);
        drain();
        check_output("lzc_err_after_find0", 64'(lzc_err), 64'd0);

        apply_stimulus(vecs[2]);
        drain();
        check_output("lzc_err_after_bad_bit", 64'(lzc_err), 64'd1);

        for (int i = 3; i < 12; i++) apply_stimulus(vecs[i]);
        drain();
        check_output("lzc_err_sticky", 64'(lzc_err), 64'd1);

        // Back-to-back beats under 1,0,0 back-pressure.
        toggle_en = 1'b1;
        for (int i = 0; i < 10; i++) apply_stimulus(vecs[i]);
        drain();
        toggle_en = 1'b0;
        idle_cycles(2);

        // One-cycle reset with two beats in flight and a beat offered during reset.
        apply_stimulus(vecs[0]);
        apply_stimulus(vecs[4]);
        #1;
        rst       = 1'b1;
        in_tvalid = 1'b1;
        in_tdata  = {vecs[5].fixp, vecs[5].lzc, vecs[5].find};
        sb_queue.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_tvalid = 1'b0;
        @(negedge clk);
        check_output("midrst_out_tvalid", 64'(out_tvalid), 64'd0);
        check_output("midrst_lzc_err",    64'(lzc_err),    64'd0);
        check_output("midrst_out_tdata",  out_tdata,       64'd0);
        idle_cycles(10);

        apply_stimulus(vecs[7]);
        drain();
        check_output("final_lzc_err", 64'(lzc_err), 64'd0);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
